kd_level_stage: RTL and testbench
=================================

// Module: kd_level_stage
// PURPOSE
//  One pipelined level of the KD-tree traversal datapath. Holds the split records
//  {median, dim index} for all 2**LEVEL internal nodes of one tree level, and
//  routes LANES query patches per cycle to a child node id.
//  Stages chain level 0 -> level DEPTH-1. The final stage's out_node is the leaf id.
//  Successor to the single-node, two-lane combinational node: adds parametrised
//  width, lanes and node count, a registered valid/ready output, config readback
//  and error reporting.
// PARAMETERS
//  DIM      5   patch dimensions per query
//  ELEM_W   11  signed width of one patch element and of a median
//  IDX_W    3   dim-index field width; needs 2**IDX_W > DIM
//  LEVEL    0   tree level of this stage; the stage holds NODES = 2**LEVEL split records
//  LANES    2   parallel query lanes
//  Derived: NODE_W = max(LEVEL,1), CFG_W = ELEM_W+IDX_W, PATCH_W = DIM*ELEM_W
// PORTS
//  clk        in   1               clock; all state updates on the rising edge
//  rst_n      in   1               asynchronous reset, active-low
//  cfg_wen    in   1               write one split record
//  cfg_waddr  in   NODE_W          record index; values >= NODES are ignored
//  cfg_wdata  in   CFG_W           {median[ELEM_W-1:0], idx[IDX_W-1:0]}
//  cfg_raddr  in   NODE_W          readback index
//  cfg_rdata  out  CFG_W           registered readback of record cfg_raddr
//  in_valid   in   LANES           per-lane query valid
//  in_ready   out  1               stage can accept; shared by all lanes
//  in_patch   in   LANES*PATCH_W   lane k occupies bits [k*PATCH_W +: PATCH_W]
//  in_node    in   LANES*NODE_W    node id at this level; ignored when LEVEL=0
//  out_valid  out  LANES           per-lane result valid
//  out_ready  in   1               downstream accepts; shared by all lanes
//  out_patch  out  LANES*PATCH_W   patch forwarded unchanged
//  out_node   out  LANES*(LEVEL+1) child id = {in_node, go_right}
//  err        out  1               sticky error flag
//  err_clr    in   1               clears err
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all records: idx = all-ones, median = 0, cfg bit = 0
//   - out_valid = 0, out_patch = 0, out_node = 0, cfg_rdata = 0, err = 0
//  Config write:
//   - Record is updated at the edge where cfg_wen=1, and its cfg bit is set.
//   - A query in that same cycle uses the old record.
//   - cfg_rdata = record[cfg_raddr], one cycle latency. Out-of-range raddr returns 0.
//  Slice and compare (lane k):
//   - elem = patch[idx*ELEM_W +: ELEM_W]
//   - go_right = !($signed(elem) < $signed(median)), so a tie goes right
//   - Record select: record[in_node] when LEVEL>0; record[0] when LEVEL=0.
//  Handshake (one register stage, latency 1):
//   - in_ready = !(|out_valid) || out_ready   (combinational)
//   - accept = in_ready. On accept, every lane loads:
//       out_valid[k] <= in_valid[k]; out_patch and out_node load for valid lanes.
//   - When !in_ready, all output registers hold. Data is never dropped or duplicated.
//   - Lanes move in lockstep. A partially valid input vector is legal.
//  Error: err is set on any accepted valid lane that hits either case below.
//   - Record with cfg bit = 0: the query is still routed using the reset values.
//   - idx >= DIM: elem is forced to 0, then compared.
//   - err_clr clears err; if a new error occurs in the same cycle, set wins.
//  Reset mid-operation: in-flight results are discarded (out_valid = 0) and all
//   records return to unconfigured; the host must reload them.
// TESTING
//  1. LEVEL=0. Load record {median=100, idx=2}. Lane0 elem2=99 -> out_node=0.
//     Lane1 elem2=100 -> out_node=1. Both out_valid=1 one cycle after accept.
//  2. Negative compare: median=-5 (11'h7FB), elem=-6 -> go_right=0; elem=-5 -> go_right=1.
//  3. LEVEL=2. Load 4 records with distinct idx. Query in_node=3 -> out_node={3,dir}.
//     cfg_rdata for raddr=3 matches the loaded record after 1 cycle.
//  4. Hold out_ready=0 for 5 cycles with a stream of queries.
//     -> in_ready=0, outputs stable. Release -> results appear in order, none lost.
//  5. Query an unconfigured node -> err=1 and the result is still emitted.
//     Pulse err_clr -> err=0. Load idx=6 (>=DIM=5) -> err=1 again.
//  6. Assert rst_n=0 while out_valid=1 -> out_valid=0 immediately and the record cfg bits clear.
//     A config write in the same cycle as a query -> that query uses the old median.

Source files
------------

// File: rtl/kd_level_stage.sv
`default_nettype none
// ============================================================================
//  Module      : kd_level_stage
//  Description : One pipelined level of a KD-tree traversal datapath. Holds the
//                split records {median, dim index} for the 2**LEVEL nodes of a
//                tree level and routes LANES query patches per cycle to a
//                child node id through a single valid/ready register stage.
//  Revision    : 1.0  initial release
// ============================================================================
module kd_level_stage #(
  parameter  int DIM     = 5,
  parameter  int ELEM_W  = 11,
  parameter  int IDX_W   = 3,
  parameter  int LEVEL   = 0,
  parameter  int LANES   = 2,
  localparam int NODE_W  = (LEVEL > 0) ? LEVEL : 1,
  localparam int CFG_W   = ELEM_W + IDX_W,
  localparam int PATCH_W = DIM * ELEM_W,
  localparam int OUT_W   = LEVEL + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_wen,
  input  logic [NODE_W-1:0]          cfg_waddr,
  input  logic [CFG_W-1:0]           cfg_wdata,
  input  logic [NODE_W-1:0]          cfg_raddr,
  output logic [CFG_W-1:0]           cfg_rdata,
  input  logic [LANES-1:0]           in_valid,
  output logic                       in_ready,
  input  logic [LANES*PATCH_W-1:0]   in_patch,
  input  logic [LANES*NODE_W-1:0]    in_node,
  output logic [LANES-1:0]           out_valid,
  input  logic                       out_ready,
  output logic [LANES*PATCH_W-1:0]   out_patch,
  output logic [LANES*OUT_W-1:0]     out_node,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int NODES = 1 << LEVEL;

  // Split record file; r_cfg marks records written since reset.
  logic signed [ELEM_W-1:0] r_median [NODES];
  logic [IDX_W-1:0]         r_idx    [NODES];
  logic [NODES-1:0]         r_cfg;

  logic [CFG_W-1:0]         r_cfg_rdata;
  logic [CFG_W-1:0]         w_rdata;

  logic [LANES-1:0]         r_out_valid;
  logic [LANES*PATCH_W-1:0] r_out_patch;
  logic [LANES*OUT_W-1:0]   r_out_node;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_err_hit;
  logic [LANES-1:0]         w_lane_err;
  logic [LANES*OUT_W-1:0]   w_child;

  // Record writes; an address with no matching node (LEVEL=0, addr 1) is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) begin
        r_median[n] <= '0;
        r_idx[n]    <= '1;
      end
      r_cfg <= '0;
    end else begin
      for (int n = 0; n < NODES; n++) begin
        if (cfg_wen && (cfg_waddr == NODE_W'(n))) begin
          r_median[n] <= cfg_wdata[CFG_W-1:IDX_W];
          r_idx[n]    <= cfg_wdata[IDX_W-1:0];
          r_cfg[n]    <= 1'b1;
        end
      end
    end
  end

  // Readback mux; unmatched addresses read as zero.
  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < NODES; n++) begin
      if (cfg_raddr == NODE_W'(n)) begin
        w_rdata = {r_median[n], r_idx[n]};
      end
    end
  end

  // Registered readback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_rdata <= '0;
    end else begin
      r_cfg_rdata <= w_rdata;
    end
  end

  // Per-lane record select, element slice and signed compare.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [NODE_W-1:0]        w_lane_node;
    logic signed [ELEM_W-1:0] w_med;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_cfg;
    logic signed [ELEM_W-1:0] w_elem;
    logic                     w_go;

    assign w_lane_node = in_node[k*NODE_W +: NODE_W];

    // Pick the record addressed by this lane; the root level has only record 0.
    always_comb begin
      w_med = r_median[0];
      w_idx = r_idx[0];
      w_cfg = r_cfg[0];
      if (LEVEL > 0) begin
        for (int n = 0; n < NODES; n++) begin
          if (w_lane_node == NODE_W'(n)) begin
            w_med = r_median[n];
            w_idx = r_idx[n];
            w_cfg = r_cfg[n];
          end
        end
      end
    end

    // Slice the indexed element; an index past the patch reads as zero.
    always_comb begin
      w_elem = '0;
      for (int d = 0; d < DIM; d++) begin
        if (w_idx == IDX_W'(d)) begin
          w_elem = in_patch[k*PATCH_W + d*ELEM_W +: ELEM_W];
        end
      end
    end

    // Ties go right.
    assign w_go          = !(w_elem < w_med);
    assign w_lane_err[k] = !w_cfg || (w_idx >= IDX_W'(DIM));

    if (LEVEL == 0) begin : g_root
      assign w_child[k*OUT_W +: OUT_W] = w_go;
    end else begin : g_inner
      assign w_child[k*OUT_W +: OUT_W] = {w_lane_node, w_go};
    end
  end

  assign w_accept  = !(|r_out_valid) || out_ready;
  assign w_err_hit = w_accept && (|(in_valid & w_lane_err));

  // Output stage: all lanes advance together whenever the stage accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= '0;
      r_out_patch <= '0;
      r_out_node  <= '0;
    end else if (w_accept) begin
      r_out_valid <= in_valid;
      for (int k = 0; k < LANES; k++) begin
        if (in_valid[k]) begin
          r_out_patch[k*PATCH_W +: PATCH_W] <= in_patch[k*PATCH_W +: PATCH_W];
          r_out_node[k*OUT_W +: OUT_W]      <= w_child[k*OUT_W +: OUT_W];
        end
      end
    end
  end

  // Sticky error flag; a new error in the clear cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_hit) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign in_ready  = w_accept;
  assign out_valid = r_out_valid;
  assign out_patch = r_out_patch;
  assign out_node  = r_out_node;
  assign cfg_rdata = r_cfg_rdata;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_kd_level_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kd_level_stage
//  Description : Bench for kd_level_stage: a LEVEL=2 instance checked every
//                cycle against a behavioural model, plus a LEVEL=0 instance
//                driven with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kd_level_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // LEVEL=2 instance signals
  logic         cfg_wen;
  logic [1:0]   cfg_waddr;
  logic [13:0]  cfg_wdata;
  logic [1:0]   cfg_raddr;
  logic [13:0]  cfg_rdata;
  logic [1:0]   in_valid;
  logic         in_ready;
  logic [109:0] in_patch;
  logic [3:0]   in_node;
  logic [1:0]   out_valid;
  logic         out_ready;
  logic [109:0] out_patch;
  logic [5:0]   out_node;
  logic         err;
  logic         err_clr;

  // LEVEL=0 instance signals
  logic         z_cfg_wen;
  logic [0:0]   z_cfg_waddr;
  logic [13:0]  z_cfg_wdata;
  logic [0:0]   z_cfg_raddr;
  logic [13:0]  z_cfg_rdata;
  logic [1:0]   z_in_valid;
  logic         z_in_ready;
  logic [109:0] z_in_patch;
  logic [1:0]   z_in_node;
  logic [1:0]   z_out_valid;
  logic         z_out_ready;
  logic [109:0] z_out_patch;
  logic [1:0]   z_out_node;
  logic         z_err;
  logic         z_err_clr;

  kd_level_stage #(.LEVEL(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch), .in_node(in_node),
    .out_valid(out_valid), .out_ready(out_ready), .out_patch(out_patch), .out_node(out_node),
    .err(err), .err_clr(err_clr)
  );

  kd_level_stage #(.LEVEL(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_wen(z_cfg_wen), .cfg_waddr(z_cfg_waddr), .cfg_wdata(z_cfg_wdata),
    .cfg_raddr(z_cfg_raddr), .cfg_rdata(z_cfg_rdata),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_patch(z_in_patch), .in_node(z_in_node),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_patch(z_out_patch), .out_node(z_out_node),
    .err(z_err), .err_clr(z_err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [54:0] mkp(input int e0, input int e1, input int e2,
                                      input int e3, input int e4);
    logic [54:0] p;
    p = {11'(e4), 11'(e3), 11'(e2), 11'(e1), 11'(e0)};
    return p;
  endfunction

  // ---------------- behavioural model of the LEVEL=2 instance ----------------
  logic signed [10:0] m_med [4];
  logic [2:0]         m_idx [4];
  bit                 m_cfg [4];
  logic [1:0]         m_ov;
  logic [54:0]        m_op [2];
  logic [2:0]         m_on [2];
  bit                 m_err;
  logic [13:0]        m_rd;

  function automatic bit model_go(input logic [54:0] p, input int node);
    int ix;
    logic signed [10:0] e;
    ix = int'(m_idx[node]);
    if (ix < 5) e = p[ix*11 +: 11];
    else        e = '0;
    return (int'(e) >= int'(m_med[node]));
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_med[n] = '0;
      m_idx[n] = 3'd7;
      m_cfg[n] = 1'b0;
    end
    m_ov  = '0;
    m_op[0] = '0; m_op[1] = '0;
    m_on[0] = '0; m_on[1] = '0;
    m_err = 1'b0;
    m_rd  = '0;
  endtask

  // Apply the effect of the rising edge that just happened, using the inputs
  // that were stable across it.
  task automatic model_step();
    logic [13:0] rd;
    bit nerr;
    int node;
    rd   = {m_med[cfg_raddr], m_idx[cfg_raddr]};
    nerr = 1'b0;
    if ((m_ov == 2'b00) || out_ready) begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k]) begin
          node    = int'(in_node[k*2 +: 2]);
          m_op[k] = in_patch[k*55 +: 55];
          m_on[k] = {in_node[k*2 +: 2], model_go(in_patch[k*55 +: 55], node)};
          if (!m_cfg[node] || (m_idx[node] >= 3'd5)) nerr = 1'b1;
        end
      end
      m_ov = in_valid;
    end
    if (nerr)         m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (cfg_wen) begin
      m_med[cfg_waddr] = cfg_wdata[13:3];
      m_idx[cfg_waddr] = cfg_wdata[2:0];
      m_cfg[cfg_waddr] = 1'b1;
    end
    m_rd = rd;
  endtask

  // Compare process: every falling edge, advance the model and check the DUT.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step();
      chk("m_in_ready", in_ready, (m_ov == 2'b00) || out_ready);
      chk("m_out_valid", out_valid, m_ov);
      chk("m_err", err, m_err);
      chk("m_cfg_rdata", cfg_rdata, m_rd);
      for (int k = 0; k < 2; k++) begin
        if (m_ov[k]) begin
          chk("m_out_patch", out_patch[k*55 +: 55], m_op[k]);
          chk("m_out_node", out_node[k*3 +: 3], m_on[k]);
        end
      end
    end
  end

  task automatic w2(input int a, input int med, input int ix);
    cfg_wen   = 1'b1;
    cfg_waddr = 2'(a);
    cfg_wdata = {11'(med), 3'(ix)};
    tick();
    cfg_wen   = 1'b0;
  endtask

  task automatic w0(input int a, input int med, input int ix);
    z_cfg_wen   = 1'b1;
    z_cfg_waddr = 1'(a);
    z_cfg_wdata = {11'(med), 3'(ix)};
    tick();
    z_cfg_wen   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [54:0] qa0, qa1, qb0, qb1;

  initial begin
    cfg_wen = 0; cfg_waddr = 0; cfg_wdata = 0; cfg_raddr = 0;
    in_valid = 0; in_patch = 0; in_node = 0; out_ready = 1; err_clr = 0;
    z_cfg_wen = 0; z_cfg_waddr = 0; z_cfg_wdata = 0; z_cfg_raddr = 0;
    z_in_valid = 0; z_in_patch = 0; z_in_node = 0; z_out_ready = 1; z_err_clr = 0;
    rst_n = 0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_out_node", out_node, 6'd0);
    chk("rst_out_patch", out_patch, 110'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_cfg_rdata", cfg_rdata, 14'd0);
    chk("rst_l0_out_valid", z_out_valid, 2'b00);
    rst_n = 1;

    // ---- LEVEL=0: median 100 on dim 2, tie goes right ----
    w0(0, 100, 2);
    z_in_valid = 2'b11;
    z_in_patch = {mkp(0, 0, 100, 0, 0), mkp(0, 0, 99, 0, 0)};
    tick();
    z_in_valid = 2'b00;
    chk("l0_valid", z_out_valid, 2'b11);
    chk("l0_node_tie", z_out_node, 2'b10);
    chk("l0_patch", z_out_patch, {mkp(0, 0, 100, 0, 0), mkp(0, 0, 99, 0, 0)});
    chk("l0_err", z_err, 1'b0);

    // ---- LEVEL=0: negative median -5 ----
    w0(0, -5, 2);
    z_in_valid = 2'b11;
    z_in_patch = {mkp(0, 0, -5, 0, 0), mkp(0, 0, -6, 0, 0)};
    tick();
    chk("l0_neg_a", z_out_node, 2'b10);
    z_in_patch = {mkp(0, 0, -1024, 0, 0), mkp(0, 0, -5, 0, 0)};
    tick();
    z_in_valid = 2'b00;
    chk("l0_neg_b", z_out_node, 2'b01);

    // ---- LEVEL=0: readback, out-of-range addresses ----
    z_cfg_raddr = 1'b0;
    tick();
    chk("l0_rdata0", z_cfg_rdata, 14'h3FDA);
    z_cfg_raddr = 1'b1;
    w0(1, 1, 0);
    chk("l0_rdata_oor", z_cfg_rdata, 14'h0000);
    z_cfg_raddr = 1'b0;
    tick();
    chk("l0_write_oor_ignored", z_cfg_rdata, 14'h3FDA);

    // ---- LEVEL=2: load records and read one back ----
    w2(0, 10, 0);
    w2(1, -20, 1);
    w2(2, 0, 3);
    w2(3, 50, 4);
    cfg_raddr = 2'd3;
    tick();
    chk("l2_rdata3", cfg_rdata, 14'h194);

    in_valid = 2'b11;
    in_node  = {2'd3, 2'd3};
    in_patch = {mkp(0, 0, 0, 0, 50), mkp(0, 0, 0, 0, 49)};
    tick();
    chk("l2_node3", out_node, 6'h3E);
    in_node  = {2'd2, 2'd1};
    in_patch = {mkp(0, 0, 0, 0, 0), mkp(0, -21, 0, 0, 0)};
    tick();
    chk("l2_mixed_nodes", out_node, 6'h2A);
    in_valid = 2'b10;
    in_node  = {2'd0, 2'd3};
    in_patch = {mkp(9, 0, 0, 0, 0), mkp(0, 0, 0, 0, 0)};
    tick();
    chk("l2_partial_valid", out_valid, 2'b10);
    chk("l2_partial_node", out_node[5:3], 3'b000);
    in_valid = 2'b00;
    tick();

    // ---- backpressure: hold out_ready low for 5 cycles ----
    qa0 = mkp(0, -19, 0, 0, 0); qa1 = mkp(11, 0, 0, 0, 0);
    qb0 = mkp(0, -30, 0, 0, 0); qb1 = mkp(5, 0, 0, 0, 0);
    out_ready = 1'b0;
    in_valid  = 2'b11;
    in_node   = {2'd0, 2'd1};
    in_patch  = {qa1, qa0};
    tick();
    in_patch  = {qb1, qb0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_patch", out_patch, {qa1, qa0});
      chk("bp_hold_node", out_node, 6'b001_011);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 2'b00;
    chk("bp_next_patch", out_patch, {qb1, qb0});
    chk("bp_next_node", out_node, 6'b000_010);
    tick();
    chk("bp_drained", out_valid, 2'b00);

    // ---- config write in the same cycle as a query uses the old record ----
    in_valid  = 2'b01;
    in_node   = {2'd0, 2'd0};
    in_patch  = {mkp(0, 0, 0, 0, 0), mkp(15, 0, 0, 0, 0)};
    w2(0, 20, 0);
    chk("wr_same_cycle_old", out_node[2:0], 3'b001);
    tick();
    in_valid = 2'b00;
    chk("wr_after_new", out_node[2:0], 3'b000);
    tick();

    // ---- reset while results are in flight ----
    out_ready = 1'b0;
    in_valid  = 2'b11;
    tick();
    chk("mid_valid_before", out_valid, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_now", out_valid, 2'b00);
    in_valid  = 2'b00;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    cfg_raddr = 2'd2;
    tick();
    chk("mid_rst_unconfigured", cfg_rdata, 14'h0007);

    // ---- errors ----
    in_valid = 2'b01;
    in_node  = {2'd0, 2'd2};
    in_patch = {mkp(0, 0, 0, 0, 0), mkp(0, 0, 0, 5, 0)};
    tick();
    in_valid = 2'b00;
    chk("err_unconfigured", err, 1'b1);
    chk("err_result_valid", out_valid, 2'b01);
    chk("err_result_node", out_node[2:0], 3'b101);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err, 1'b0);
    w2(1, 3, 6);
    in_valid = 2'b10;
    in_node  = {2'd1, 2'd0};
    in_patch = {mkp(9, 9, 9, 9, 9), mkp(0, 0, 0, 0, 0)};
    tick();
    chk("err_idx_ge_dim", err, 1'b1);
    chk("err_idx_node", out_node[5:3], 3'b010);
    err_clr = 1'b1;
    tick();
    chk("err_set_wins", err, 1'b1);
    in_valid = 2'b00;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", err, 1'b0);
    w2(0, 10, 0);
    in_valid = 2'b01;
    in_node  = {2'd3, 2'd0};
    tick();
    in_valid = 2'b00;
    chk("err_invalid_lane_ignored", err, 1'b0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
